gpio_mmio_port: RTL and testbench

Memory-mapped GPIO responder for the multicycle MIPS core. It serves the core's load/store accesses to the GPIO address window: it owns the output register that drives the board LEDs, and it returns synchronized, debounced switch inputs. It also latches rising edges on those inputs into a sticky status register and raises an interrupt line. It sits between the core's data-bus port and the board pins, alongside data memory in the address decode.

---
 rtl/gpio_mmio_port.sv | 119 +++++++++++
 tb/tb_gpio_mmio_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mmio_port.sv
// GPIO responder on the core data bus: LED output register, debounced switch
// inputs, and sticky rising-edge status with a level interrupt.
module gpio_mmio_port #(
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                we,
  input  logic                re,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                rvalid,
  input  logic [IN_WIDTH-1:0] gpio_i,
  output logic [31:0]         gpio_o,
  output logic                irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0] r_s1;
  logic [IN_WIDTH-1:0] r_s2;
  logic [IN_WIDTH-1:0] r_edge_en;
  logic [IN_WIDTH-1:0] r_edge_st;
  logic [31:0]         r_out;
  logic [31:0]         r_rdata;
  logic                r_rvalid;
  logic                r_irq;

  logic [IN_WIDTH-1:0] w_db;
  logic [IN_WIDTH-1:0] w_rise;
  logic [IN_WIDTH-1:0] w_clr;
  logic [IN_WIDTH-1:0] w_st_next;
  logic [31:0]         w_in32;
  logic [31:0]         w_en32;
  logic [31:0]         w_st32;
  logic [31:0]         w_rd;
  logic                w_wr;
  logic                w_rd_en;

  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_bit
      logic          r_db_bit;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_db_bit <= 1'b0;
          r_cnt    <= '0;
        end else if (r_s2[gi] == r_db_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_db_bit <= r_s2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi]   = r_db_bit;
      // High on the exact edge where db is about to go 0 -> 1.
      assign w_rise[gi] = r_s2[gi] && !r_db_bit && (r_cnt == CNT_MAX);
    end
  endgenerate

  assign w_wr    = sel && we;
  assign w_rd_en = sel && re;

  always_comb begin
    w_in32 = '0;
    w_en32 = '0;
    w_st32 = '0;
    w_in32[IN_WIDTH-1:0] = w_db;
    w_en32[IN_WIDTH-1:0] = r_edge_en;
    w_st32[IN_WIDTH-1:0] = r_edge_st;
    case (addr)
      2'd0:    w_rd = r_out;
      2'd1:    w_rd = w_in32;
      2'd2:    w_rd = w_en32;
      default: w_rd = w_st32;
    endcase
  end

  // A new edge wins over a simultaneous write-1-to-clear.
  assign w_clr     = (w_wr && addr == 2'd3) ? wdata[IN_WIDTH-1:0] : '0;
  assign w_st_next = (r_edge_st & ~w_clr) | (w_rise & r_edge_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_edge_en <= '0;
      r_edge_st <= '0;
      r_out     <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_s1      <= gpio_i;
      r_s2      <= r_s1;
      r_edge_st <= w_st_next;
      r_irq     <= |w_st_next;
      r_rvalid  <= w_rd_en;
      if (w_rd_en) r_rdata <= w_rd;
      if (w_wr && addr == 2'd0) r_out <= wdata;
      if (w_wr && addr == 2'd2) r_edge_en <= wdata[IN_WIDTH-1:0];
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign gpio_o = r_out;
  assign irq    = r_irq;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Bench for gpio_mmio_port: reads push expectations into a scoreboard that a
// monitor drains on every rvalid; direct checks cover gpio_o, irq and reset.
module tb_gpio_mmio_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  gpio_i = 8'd0;
  logic [31:0] gpio_o;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  gpio_mmio_port #(.IN_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got 0x%08h", name, act);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
    sel = 1'b1; re = 1'b1; addr = a;
    exp_q.push_back(e);
    name_q.push_back(name);
    tick();
    sel = 1'b0; re = 1'b0;
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no read", rdata);
        end else begin
          automatic logic [31:0] e = exp_q.pop_front();
          automatic string nm = name_q.pop_front();
          chk(nm, rdata, e);
        end
      end
    end
  end

  initial begin
    // Reset and idle outputs
    idle(2);
    rst = 1'b0;
    chk("rst_gpio_o", gpio_o, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rd(2'd0, 32'h0, "rst_out");
    rd(2'd1, 32'h0, "rst_in");
    rd(2'd2, 32'h0, "rst_en");
    rd(2'd3, 32'h0, "rst_st");

    // OUT write/read, single-cycle rvalid
    wr(2'd0, 32'h0000_01A5);
    chk("gpio_o_write", gpio_o, 32'h0000_01A5);
    rd(2'd0, 32'h0000_01A5, "out_read");
    tick();
    chk("rvalid_one_cycle", {31'd0, rvalid}, 32'h0);

    // Debounce latency: db updates at edge k+5, so a read at k+5 sees old value
    gpio_i = 8'h01;
    idle(5);
    rd(2'd1, 32'h00, "in_before_accept");
    rd(2'd1, 32'h01, "in_after_accept");

    // 3-cycle glitch on bit 1 is rejected
    gpio_i = 8'h03;
    idle(3);
    gpio_i = 8'h01;
    idle(10);
    rd(2'd1, 32'h01, "glitch_rejected");

    // Edge capture
    wr(2'd2, 32'h0F);
    rd(2'd2, 32'h0F, "edge_en_read");
    gpio_i = 8'h00;
    idle(10);
    rd(2'd3, 32'h00, "st_before_rise");
    gpio_i = 8'h0C;
    idle(10);
    rd(2'd3, 32'h0C, "st_rise_0c");
    chk("irq_after_rise", {31'd0, irq}, 32'h1);
    gpio_i = 8'h00;
    idle(10);
    rd(2'd3, 32'h0C, "st_fall_ignored");
    gpio_i = 8'h80;
    idle(10);
    rd(2'd3, 32'h0C, "st_disabled_bit");
    rd(2'd1, 32'h80, "in_bit7");
    gpio_i = 8'h00;
    idle(10);

    // Write-1-to-clear
    wr(2'd3, 32'h04);
    rd(2'd3, 32'h08, "w1c_partial");
    chk("irq_partial", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h08);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd(2'd3, 32'h00, "w1c_all");

    // Set and clear of bit 0 on the same edge: set wins
    gpio_i = 8'h01;
    idle(5);
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h01, "set_beats_clear");
    chk("irq_collision", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h00, "st_cleared_again");

    // Read during write returns the old value
    sel = 1'b1; we = 1'b1; re = 1'b1; addr = 2'd2; wdata = 32'h03;
    exp_q.push_back(32'h0F);
    name_q.push_back("rdw_old_value");
    tick();
    sel = 1'b0; we = 1'b0; re = 1'b0;
    rd(2'd2, 32'h03, "rdw_new_value");

    // Unselected access is ignored
    we = 1'b1; re = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF;
    tick();
    chk("unsel_rvalid", {31'd0, rvalid}, 32'h0);
    chk("unsel_gpio_o", gpio_o, 32'h0000_01A5);
    chk("unsel_rdata_hold", rdata, 32'h03);
    we = 1'b0; re = 1'b0;
    rd(2'd0, 32'h0000_01A5, "unsel_out_kept");

    // Fill EDGE_ST, then reset mid-debounce
    gpio_i = 8'h00;
    idle(10);
    wr(2'd2, 32'hFF);
    gpio_i = 8'hFF;
    idle(10);
    rd(2'd3, 32'hFF, "st_all_set");
    gpio_i = 8'h00;
    idle(10);
    gpio_i = 8'h01;
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("midrst_gpio_o", gpio_o, 32'h0);
    chk("midrst_irq", {31'd0, irq}, 32'h0);
    chk("midrst_rvalid", {31'd0, rvalid}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    idle(5);
    rd(2'd1, 32'h00, "post_rst_in_early");
    rd(2'd1, 32'h01, "post_rst_in_accept");
    rd(2'd3, 32'h00, "post_rst_st");
    rd(2'd2, 32'h00, "post_rst_en");
    rd(2'd0, 32'h00, "post_rst_out");
    chk("post_rst_irq", {31'd0, irq}, 32'h0);

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
